dsp_equation_dispatch: RTL

Parametrised dispatcher between the DSP slave register block and NUM_EQ equation engines. It latches the requested equation number on a start pulse and drives a one-hot enable to the selected engine only. It routes that engine's file-bus traffic and captures its result and status. It adds sequencing the combinational selector lacked: a run state machine, a timeout watchdog, abort, sticky done/error and a single-cycle interrupt.

---
 rtl/dsp_equation_dispatch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dsp_equation_dispatch.sv
// Dispatcher between the DSP register block and NUM_EQ equation engines: one-hot enable, file-bus routing, result/status capture.
// Latency: start -> eq_enable 1 cycle; engine done -> interrupt 1 cycle (FINISH); engine done -> done flag 2 cycles.
// No backpressure: start/clear are ignored outside IDLE, and abort is honoured only in RUN. Optional DSP_DISPATCH_CYCLE_COUNT_EN adds cycle_count.
module dsp_equation_dispatch #(
    parameter int NUM_EQ = 4,
    parameter int dw     = 32,
    parameter int SEL_W  = 8,
    parameter int TMO_W  = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [SEL_W-1:0]       eq_sel,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   clear,
    input  logic [TMO_W-1:0]       timeout_limit,
    input  logic [NUM_EQ-1:0]      eq_done,
    input  logic [NUM_EQ-1:0]      eq_error,
    input  logic [NUM_EQ*8-1:0]    eq_file_num,
    input  logic [NUM_EQ-1:0]      eq_file_write,
    input  logic [NUM_EQ-1:0]      eq_file_read,
    input  logic [NUM_EQ*32-1:0]   eq_file_write_data,
    input  logic [NUM_EQ*dw-1:0]   eq_result,
    output logic [NUM_EQ-1:0]      eq_enable,
    output logic [7:0]             file_num,
    output logic                   file_write,
    output logic                   file_read,
    output logic [31:0]            file_write_data,
    output logic [dw-1:0]          result,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   interrupt,
    output logic [1:0]             status
`ifdef DSP_DISPATCH_CYCLE_COUNT_EN
    ,
    output logic [TMO_W-1:0]       cycle_count
`endif
);

    localparam int SLOT_W = (NUM_EQ > 1) ? $clog2(NUM_EQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [TMO_W-1:0]    cnt;
    logic [TMO_W-1:0]    cnt_next;
    logic                sel_valid;
    logic [NUM_EQ-1:0]   start_onehot;
    logic                sel_done;
    logic                sel_err;
    logic [dw-1:0]       sel_result;
    logic                tmo_hit;
    logic                run_exit;

    // Decode the requested equation number into a validity flag and the one-hot enable it would produce
    always_comb begin
        sel_valid    = (eq_sel != '0) && (int'(eq_sel) <= NUM_EQ);
        start_onehot = '0;
        for (int i = 0; i < NUM_EQ; i++) begin
            if (eq_sel == SEL_W'(i + 1)) start_onehot[i] = 1'b1;
        end
    end

    // Select the latched slot's status, result and file bus; file bus is forced to zero outside RUN
    always_comb begin
        sel_done        = 1'b0;
        sel_err         = 1'b0;
        sel_result      = '0;
        file_num        = '0;
        file_write      = 1'b0;
        file_read       = 1'b0;
        file_write_data = '0;
        for (int i = 0; i < NUM_EQ; i++) begin
            if (slot == SLOT_W'(i)) begin
                sel_done   = eq_done[i];
                sel_err    = eq_error[i];
                sel_result = eq_result[i*dw +: dw];
                if (state == RUN) begin
                    file_num        = eq_file_num[i*8 +: 8];
                    file_write      = eq_file_write[i];
                    file_read       = eq_file_read[i];
                    file_write_data = eq_file_write_data[i*32 +: 32];
                end
            end
        end
    end

    // Watchdog compare and saturating run-length increment
    always_comb begin
        cnt_next = (cnt == '1) ? cnt : cnt + TMO_W'(1);
        tmo_hit  = (timeout_limit != '0) && (cnt == timeout_limit - TMO_W'(1));
        run_exit = abort | sel_err | sel_done | tmo_hit;
    end

    assign busy = (state == RUN);

    // Run sequencer: error/status/interrupt land on the exit edge, done follows one cycle later out of FINISH
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= IDLE;
            slot      <= '0;
            cnt       <= '0;
            eq_enable <= '0;
            result    <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            interrupt <= 1'b0;
            status    <= 2'd0;
`ifdef DSP_DISPATCH_CYCLE_COUNT_EN
            cycle_count <= '0;
`endif
        end else begin
            interrupt <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        cnt   <= '0;
                        if (sel_valid) begin
                            slot      <= SLOT_W'(eq_sel - 1'b1);
                            eq_enable <= start_onehot;
                            error     <= 1'b0;
                            status    <= 2'd0;
                            state     <= RUN;
`ifdef DSP_DISPATCH_CYCLE_COUNT_EN
                            cycle_count <= '0;
`endif
                        end else begin
                            error     <= 1'b1;
                            status    <= 2'd3;
                            interrupt <= 1'b1;
                            state     <= FINISH;
                        end
                    end else if (clear) begin
                        done   <= 1'b0;
                        error  <= 1'b0;
                        status <= 2'd0;
                    end
                end
                RUN: begin
                    cnt <= cnt_next;
                    if (run_exit) begin
                        eq_enable <= '0;
                        interrupt <= 1'b1;
                        state     <= FINISH;
`ifdef DSP_DISPATCH_CYCLE_COUNT_EN
                        cycle_count <= cnt_next;
`endif
                        // Engine error outranks a coincident done, so the result is only taken on a clean finish
                        if (abort) begin
                            status <= 2'd3;
                            error  <= 1'b1;
                        end else if (sel_err) begin
                            status <= 2'd1;
                            error  <= 1'b1;
                        end else if (sel_done) begin
                            status <= 2'd0;
                            result <= sel_result;
                        end else begin
                            status <= 2'd2;
                            error  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
